// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing (pixel enable, counters, syncs); VGA_FRAME_TICK_EN adds frame_tick
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);
  localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISPLAY + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  logic [DW-1:0] div_cnt;
  logic [9:0] x_n, y_n;
  logic x_wrap, y_wrap;
  always_comb begin
    x_wrap = pixel_x == 10'(H_TOTAL - 1);
    y_wrap = pixel_y == 10'(V_TOTAL - 1);
    x_n = p_tick ? (x_wrap ? 10'd0 : pixel_x + 10'd1) : pixel_x;
    y_n = (p_tick && x_wrap) ? (y_wrap ? 10'd0 : pixel_y + 10'd1) : pixel_y;
  end
  assign video_on = pixel_x < 10'(H_DISPLAY) && pixel_y < 10'(V_DISPLAY);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      div_cnt <= div_cnt == DIV_MAX ? '0 : div_cnt + 1'b1;
      p_tick  <= div_cnt == DIV_MAX;
      pixel_x <= x_n;
      pixel_y <= y_n;
      hsync   <= !(x_n >= 10'(HS_START) && x_n <= 10'(HS_END));
      vsync   <= !(y_n >= 10'(VS_START) && y_n <= 10'(VS_END));
    end
  end
`ifdef VGA_FRAME_TICK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_tick <= 1'b0;
    else       frame_tick <= p_tick && x_wrap && y_wrap;
  end
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: vectors, async-reset sequences and randomized resets against an arithmetic raster model
module tb_vga_sync_gen;
  localparam int SD = 3, SHD = 8, SHF = 2, SHS = 3, SHB = 2, SVD = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int DD = 2, DHD = 640, DHF = 16, DHS = 96, DHB = 48, DVD = 480, DVF = 10, DVS = 2, DVB = 33;
  typedef struct {int x; int y; bit hs; bit vs; bit vo; bit pt; bit ft;} obs_t;
  typedef struct {int t; obs_t o;} vec_t;
  logic clk = 1'b0;
  logic rstn_s = 1'b1, rstn_d = 1'b1;
  logic hs_s, vs_s, vo_s, pt_s, hs_d, vs_d, vo_d, pt_d;
  logic [9:0] x_s, y_s, x_d, y_d;
  logic ft_s, ft_d;
  int checks = 0, errors = 0;
  int t_s, t_d;
  int hs_low_d = 0, vo_cnt_s = 0, ft_cnt_s = 0;
  bit first_s = 1'b1;
  obs_t as_, ad_;
  vec_t tab[$];
  always #5 clk = ~clk;
  vga_sync_gen #(.CLK_DIV(SD), .H_DISPLAY(SHD), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                 .V_DISPLAY(SVD), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_small (
    .clk(clk), .rstn(rstn_s), .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .p_tick(pt_s),
    .pixel_x(x_s), .pixel_y(y_s)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft_s)
`endif
  );
  vga_sync_gen u_def (
    .clk(clk), .rstn(rstn_d), .hsync(hs_d), .vsync(vs_d), .video_on(vo_d), .p_tick(pt_d),
    .pixel_x(x_d), .pixel_y(y_d)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(ft_d)
`endif
  );
`ifndef VGA_FRAME_TICK_EN
  assign ft_s = 1'b0;
  assign ft_d = 1'b0;
`endif
  always @(posedge clk or negedge rstn_s) if (!rstn_s) t_s <= 0; else t_s <= t_s + 1;
  always @(posedge clk or negedge rstn_d) if (!rstn_d) t_d <= 0; else t_d <= t_d + 1;
  function automatic int cnt_at(input int t, input int d);
    return t == 0 ? 0 : (t - 1) / d;
  endfunction
  function automatic obs_t model(input int t, input int d, input int hd, input int hf, input int hsw,
                                 input int hb, input int vd, input int vf, input int vsw, input int vb);
    obs_t o;
    int ht = hd + hf + hsw + hb;
    int vt = vd + vf + vsw + vb;
    int k = cnt_at(t, d) % (ht * vt);
    o.x  = k % ht;
    o.y  = k / ht;
    o.hs = !(o.x >= hd + hf && o.x < hd + hf + hsw);
    o.vs = !(o.y >= vd + vf && o.y < vd + vf + vsw);
    o.vo = o.x < hd && o.y < vd;
    o.pt = t > 0 && t % d == 0;
    o.ft = t >= 2 && cnt_at(t, d) != cnt_at(t - 1, d) && k == 0;
    return o;
  endfunction
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    cmp({tag, " pixel_x"}, a.x, e.x);
    cmp({tag, " pixel_y"}, a.y, e.y);
    cmp({tag, " hsync"}, int'(a.hs), int'(e.hs));
    cmp({tag, " vsync"}, int'(a.vs), int'(e.vs));
    cmp({tag, " video_on"}, int'(a.vo), int'(e.vo));
    cmp({tag, " p_tick"}, int'(a.pt), int'(e.pt));
`ifdef VGA_FRAME_TICK_EN
    cmp({tag, " frame_tick"}, int'(a.ft), int'(e.ft));
`endif
  endtask
  function automatic vec_t mk(input int t, input int x, input int y, input bit hs, input bit vs,
                              input bit vo, input bit pt, input bit ft);
    vec_t v;
    v.t = t; v.o.x = x; v.o.y = y; v.o.hs = hs; v.o.vs = vs; v.o.vo = vo; v.o.pt = pt; v.o.ft = ft;
    return v;
  endfunction
  task automatic chk_reset_vals(input string tag);
    cmp({tag, " pixel_x"}, int'(x_s), 0);
    cmp({tag, " pixel_y"}, int'(y_s), 0);
    cmp({tag, " hsync"}, int'(hs_s), 1);
    cmp({tag, " vsync"}, int'(vs_s), 1);
    cmp({tag, " p_tick"}, int'(pt_s), 0);
    cmp({tag, " video_on"}, int'(vo_s), 1);
`ifdef VGA_FRAME_TICK_EN
    cmp({tag, " frame_tick"}, int'(ft_s), 0);
`endif
  endtask
  always @(negedge clk) begin
    as_ = '{int'(x_s), int'(y_s), hs_s, vs_s, vo_s, pt_s, ft_s};
    ad_ = '{int'(x_d), int'(y_d), hs_d, vs_d, vo_d, pt_d, ft_d};
    cmp_obs($sformatf("small t=%0d", t_s), as_, model(t_s, SD, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB));
    cmp_obs($sformatf("default t=%0d", t_d), ad_, model(t_d, DD, DHD, DHF, DHS, DHB, DVD, DVF, DVS, DVB));
    if (t_d >= 1 && t_d <= 1600 && !hs_d) hs_low_d++;
    if (first_s && t_s >= 1 && t_s <= 495 && vo_s) vo_cnt_s++;
    if (first_s && t_s >= 1 && ft_s) ft_cnt_s++;
  end
  initial begin
    tab.push_back(mk(0,   0,  0, 1, 1, 1, 0, 0));
    tab.push_back(mk(2,   0,  0, 1, 1, 1, 0, 0));
    tab.push_back(mk(3,   0,  0, 1, 1, 1, 1, 0));
    tab.push_back(mk(4,   1,  0, 1, 1, 1, 0, 0));
    tab.push_back(mk(30,  9,  0, 1, 1, 0, 1, 0));
    tab.push_back(mk(31,  10, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(39,  12, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(40,  13, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(46,  0,  1, 1, 1, 1, 0, 0));
    tab.push_back(mk(316, 0,  7, 1, 0, 0, 0, 0));
    tab.push_back(mk(375, 4,  8, 1, 0, 0, 1, 0));
    tab.push_back(mk(376, 5,  8, 1, 0, 0, 0, 0));
    tab.push_back(mk(406, 0,  9, 1, 1, 0, 0, 0));
    tab.push_back(mk(495, 14, 10, 1, 1, 0, 1, 0));
    tab.push_back(mk(496, 0,  0, 1, 1, 1, 0, 1));
    tab.push_back(mk(497, 0,  0, 1, 1, 1, 0, 0));
    #1 rstn_s = 1'b0; rstn_d = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("in reset");
    rstn_s = 1'b1; rstn_d = 1'b1;
    for (int i = 0; i < tab.size(); i++) begin
      int g = 0;
      while (t_s < tab[i].t && g < 3000) begin @(negedge clk); g++; end
      cmp($sformatf("vec%0d reached t", i), t_s, tab[i].t);
      as_ = '{int'(x_s), int'(y_s), hs_s, vs_s, vo_s, pt_s, ft_s};
      cmp_obs($sformatf("vec%0d", i), as_, tab[i].o);
    end
    begin
      int g = 0;
      while (t_s < 890 && g < 3000) begin @(negedge clk); g++; end
    end
    cmp("pre-reset t", t_s, 890);
    cmp("pre-reset hsync", int'(hs_s), 0);
    cmp("pre-reset vsync", int'(vs_s), 0);
    cmp("pre-reset pixel_x", int'(x_s), 11);
    cmp("pre-reset pixel_y", int'(y_s), 8);
    first_s = 1'b0;
    #2 rstn_s = 1'b0;
    #1 chk_reset_vals("async reset");
    repeat (2) @(negedge clk);
    rstn_s = 1'b1;
    repeat (3) @(negedge clk);
    cmp("restart p_tick", int'(pt_s), 1);
    cmp("restart pixel_x", int'(x_s), 0);
    @(negedge clk);
    cmp("restart step pixel_x", int'(x_s), 1);
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      #($urandom_range(1, 3)) rstn_s = 1'b0;
      #1 chk_reset_vals($sformatf("rand reset %0d", r));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rstn_s = 1'b1;
    end
    begin
      int g = 0;
      while (t_d < 3300 && g < 5000) begin @(negedge clk); g++; end
    end
    cmp("default run length", int'(t_d >= 3300), 1);
    cmp("hsync low clks per line", hs_low_d, 192);
    cmp("video_on clks per small frame", vo_cnt_s, 144);
`ifdef VGA_FRAME_TICK_EN
    cmp("frame_tick count", ft_cnt_s, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
